// File: rtl/axi_sram_slave.sv
// AXI4 memory slave backed by a word-addressed single-clock RAM.
// Independent write and read state machines, one transaction outstanding each.
// FIXED and INCR bursts are served; WRAP and reserved bursts are handshaked
// normally but answered with SLVERR (writes dropped, reads return zero).
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats until the counter reaches awlen
// W_RESP | bvalid high, holding bid/bresp until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting beats until the last one is taken
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Size and out-of-range address bits carry no meaning for this RAM.
  logic unused_bits;
  assign unused_bits = ^{s_awsize, s_arsize, s_awaddr, s_araddr};

  // ---------------- write path ----------------
  w_state_t             w_state, w_next;
  logic                 aw_rdy_q;
  logic [ID_WIDTH-1:0]  w_id;
  logic [IDX_W-1:0]     w_idx;
  logic [7:0]           w_len, w_cnt;
  logic                 w_fixed, w_bad_burst, w_bad_last;
  logic                 aw_hs, w_hs, b_hs, w_final;

  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign b_hs    = s_bvalid && s_bready;
  assign w_final = (w_cnt == w_len);

  // Write state register; awready is registered so it stays low through reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      aw_rdy_q <= 1'b0;
    end else begin
      w_state  <= w_next;
      aw_rdy_q <= (w_next == W_IDLE);
    end
  end

  // Write next-state: beat count alone ends the burst, wlast is only checked.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel outputs.
  always_comb begin
    s_awready = aw_rdy_q;
    s_wready  = (w_state == W_DATA);
    s_bvalid  = (w_state == W_RESP);
    s_bid     = w_id;
    s_bresp   = (w_bad_burst || w_bad_last) ? RESP_SLVERR : RESP_OKAY;
  end

  // Write burst bookkeeping: address capture, beat counting, wlast checking.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id        <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_fixed     <= 1'b0;
      w_bad_burst <= 1'b0;
      w_bad_last  <= 1'b0;
    end else if (aw_hs) begin
      w_id        <= s_awid;
      w_idx       <= s_awaddr[OFF_W +: IDX_W];
      w_len       <= s_awlen;
      w_cnt       <= '0;
      w_fixed     <= (s_awburst == BURST_FIXED);
      w_bad_burst <= s_awburst[1];
      w_bad_last  <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_idx <= w_idx + IDX_ONE;
      if (s_wlast != w_final) w_bad_last <= 1'b1;
    end
  end

  // RAM byte writes; contents survive reset and are never initialised.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_bad_burst) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_next;
  logic                  ar_rdy_q;
  logic [ID_WIDTH-1:0]   r_id;
  logic [IDX_W-1:0]      r_idx, r_next_idx, ar_idx;
  logic [7:0]            r_len, r_cnt;
  logic                  r_fixed, r_bad;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  ar_hs, r_hs, r_final;

  assign ar_hs      = s_arvalid && s_arready;
  assign r_hs       = s_rvalid && s_rready;
  assign r_final    = (r_cnt == r_len);
  assign ar_idx     = s_araddr[OFF_W +: IDX_W];
  assign r_next_idx = r_fixed ? r_idx : (r_idx + IDX_ONE);

  // Read state register; arready registered like awready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      ar_rdy_q <= 1'b0;
    end else begin
      r_state  <= r_next;
      ar_rdy_q <= (r_next == R_IDLE);
    end
  end

  // Read next-state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read channel outputs.
  always_comb begin
    s_arready = ar_rdy_q;
    s_rvalid  = (r_state == R_DATA);
    s_rlast   = (r_state == R_DATA) && r_final;
    s_rid     = r_id;
    s_rdata   = r_data;
    s_rresp   = r_bad ? RESP_SLVERR : RESP_OKAY;
  end

  // Read burst bookkeeping; rdata is loaded one beat ahead so it is stable
  // while stalled, and a same-edge write is seen as the old word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_bad   <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= s_arid;
      r_idx   <= ar_idx;
      r_len   <= s_arlen;
      r_cnt   <= '0;
      r_fixed <= (s_arburst == BURST_FIXED);
      r_bad   <= s_arburst[1];
      r_data  <= s_arburst[1] ? '0 : mem[ar_idx];
    end else if (r_hs && !r_final) begin
      r_idx  <= r_next_idx;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= r_bad ? '0 : mem[r_next_idx];
    end
  end

endmodule
